// File: rtl/serializer_scheduler.sv
// Round-robin scheduler that shares one serializer between NUM_REQ frame buffers.
// A watchdog abandons a transfer whose serializer never reports done.
module serializer_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int INPUT_SIZE  = 256,
   parameter int OUTPUT_SIZE = 16,
   parameter int TIMEOUT     = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*INPUT_SIZE-1:0] req_data,
   output logic [NUM_REQ-1:0]            ack,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy,
   output logic                          ser_start,
   output logic [INPUT_SIZE-1:0]         ser_data,
   input  logic                          ser_done,
   output logic                          timeout_err
);

   localparam int IDW       = $clog2(NUM_REQ);
   localparam int NUM_WORDS = INPUT_SIZE / OUTPUT_SIZE;
   localparam int CW        = $clog2(TIMEOUT);
   localparam logic [CW-1:0]  LAST_COUNT = CW'(TIMEOUT - 1);
   localparam logic [IDW-1:0] LAST_IDX   = IDW'(NUM_REQ - 1);

   // The watchdog must outlast a healthy serialization.
   if (TIMEOUT <= NUM_WORDS + 1) begin : gBadTimeout
      $error("serializer_scheduler: TIMEOUT must exceed NUM_WORDS+1");
   end

   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

   state_t                  state_q, state_d;
   logic [NUM_REQ-1:0]      ack_q, ack_d;
   logic [IDW-1:0]          grant_q, grant_d;
   logic [IDW-1:0]          lastGrant_q, lastGrant_d;
   logic                    busy_q, busy_d;
   logic                    start_q, start_d;
   logic [INPUT_SIZE-1:0]   data_q, data_d;
   logic                    timeoutErr_q, timeoutErr_d;
   logic [CW-1:0]           count_q, count_d;

   logic [INPUT_SIZE-1:0]   frame [NUM_REQ];
   logic [NUM_REQ-1:0]      eligible;
   logic [IDW-1:0]          cand;
   logic [IDW-1:0]          pick;
   logic                    found;

   for (genvar g = 0; g < NUM_REQ; g++) begin : gFrame
      assign frame[g] = req_data[g*INPUT_SIZE +: INPUT_SIZE];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         ack_q        <= '0;
         grant_q      <= '0;
         lastGrant_q  <= LAST_IDX;
         busy_q       <= 1'b0;
         start_q      <= 1'b0;
         data_q       <= '0;
         timeoutErr_q <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         ack_q        <= ack_d;
         grant_q      <= grant_d;
         lastGrant_q  <= lastGrant_d;
         busy_q       <= busy_d;
         start_q      <= start_d;
         data_q       <= data_d;
         timeoutErr_q <= timeoutErr_d;
         count_q      <= count_d;
      end
   end

   // The requester acked this cycle is masked so a lingering req cannot win again.
   always_comb begin
      eligible = req & ~ack_q;
      found    = 1'b0;
      pick     = '0;
      cand     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDW'((int'(lastGrant_q) + k) % NUM_REQ);
         if (!found && eligible[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      ack_d        = '0;
      grant_d      = grant_q;
      lastGrant_d  = lastGrant_q;
      busy_d       = 1'b0;
      start_d      = 1'b0;
      data_d       = data_q;
      timeoutErr_d = timeoutErr_q;
      count_d      = count_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = START;
               grant_d = pick;
               data_d  = frame[pick];
               start_d = 1'b1;
               busy_d  = 1'b1;
            end
         end
         START: begin
            state_d = WAIT;
            busy_d  = 1'b1;
            count_d = '0;
         end
         WAIT: begin
            if (ser_done) begin
               state_d        = IDLE;
               ack_d[grant_q] = 1'b1;
               lastGrant_d    = grant_q;
            end else if (count_q == LAST_COUNT) begin
               state_d      = IDLE;
               timeoutErr_d = 1'b1;
               lastGrant_d  = grant_q;
            end else begin
               busy_d  = 1'b1;
               count_d = count_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ack         = ack_q;
   assign grant_id    = grant_q;
   assign busy        = busy_q;
   assign ser_start   = start_q;
   assign ser_data    = data_q;
   assign timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_serializer_scheduler.sv
// Directed bench for serializer_scheduler: arbitration order, latency, watchdog,
// mid-transfer reset and data hold, against hand-computed expectations.
module tb_serializer_scheduler;

   localparam int NUM_REQ     = 4;
   localparam int INPUT_SIZE  = 256;
   localparam int OUTPUT_SIZE = 16;
   localparam int TIMEOUT     = 32;
   localparam int NUM_WORDS   = INPUT_SIZE / OUTPUT_SIZE;

   typedef struct {
      int         cycles;
      logic [3:0] req;
      logic [3:0] expAck;
      logic       expStart;
      logic       expBusy;
      logic [1:0] expGrant;
      logic       expTo;
      string      name;
   } vec_t;

   logic                          clk = 1'b0;
   logic                          reset;
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*INPUT_SIZE-1:0] reqData;
   logic [NUM_REQ-1:0]            ack;
   logic [1:0]                    grantId;
   logic                          busy;
   logic                          serStart;
   logic [INPUT_SIZE-1:0]         serData;
   logic                          serDone;
   logic                          timeoutErr;
   logic                          modelNeverDone = 1'b0;
   logic [INPUT_SIZE-1:0]         frames [NUM_REQ];
   int                            checks = 0;
   int                            failures = 0;

   serializer_scheduler #(
      .NUM_REQ(NUM_REQ), .INPUT_SIZE(INPUT_SIZE),
      .OUTPUT_SIZE(OUTPUT_SIZE), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(reqData), .ack(ack),
      .grant_id(grantId), .busy(busy), .ser_start(serStart), .ser_data(serData),
      .ser_done(serDone), .timeout_err(timeoutErr)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Serializer stand-in: done goes high NUM_WORDS+1 cycles after the start
   // pulse is seen, unless a reset intervenes or it is told to hang.
   initial begin : serializerModel
      bit aborted;
      serDone = 1'b0;
      forever begin
         @(posedge clk); #2;
         if (serStart && !reset) begin
            aborted = 1'b0;
            for (int i = 0; i < NUM_WORDS + 1; i++) begin
               @(posedge clk); #2;
               if (reset) begin
                  aborted = 1'b1;
                  break;
               end
            end
            if (!aborted && !modelNeverDone) begin
               serDone = 1'b1;
               @(posedge clk); #2;
               serDone = 1'b0;
            end
         end
      end
   end

   // Hard stop in case the scenario sequencing itself wedges.
   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      req = v.req;
      tick(v.cycles);
      checkOutput({v.name, " ack"}, ack, v.expAck);
      checkOutput({v.name, " ser_start"}, serStart, v.expStart);
      checkOutput({v.name, " busy"}, busy, v.expBusy);
      checkOutput({v.name, " grant_id"}, grantId, v.expGrant);
      checkOutput({v.name, " timeout_err"}, timeoutErr, v.expTo);
   endtask

   task automatic resetDut();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   // Follows a run of back-to-back transfers; requesters drop req on their ack.
   task automatic watchGrants(input int nGrants, input logic [7:0] order, input int firstStart,
                              input bit haveInflight, input logic [1:0] inflight, input int budget);
      int         k = 0;
      int         acks = 0;
      int         expAcks = nGrants + (haveInflight ? 1 : 0);
      logic [1:0] cur = inflight;
      for (int t = 1; t <= budget; t++) begin
         tick(1);
         if (serStart) begin
            if (k < nGrants) begin
               checkOutput("rr start cycle", t, firstStart + (NUM_WORDS + 3) * k);
               checkOutput("rr grant_id", grantId, order[2*k +: 2]);
               cur = order[2*k +: 2];
            end else begin
               checkOutput("rr extra grant", k, nGrants - 1);
            end
            k++;
         end
         if (ack != 4'b0000) begin
            checkOutput("rr ack onehot", ack, 4'b0001 << cur);
            req = req & ~ack;
            acks++;
            if (acks == expAcks) break;
         end
      end
      checkOutput("rr grant count", k, nGrants);
      checkOutput("rr ack count", acks, expAcks);
   endtask

   // Scenario sequence; each block starts with the DUT idle.
   initial begin : mainTest
      vec_t vecs [6];
      frames[0] = {4{64'h0123_4567_89AB_CDEF}};
      frames[1] = {8{32'h1111_2222}};
      frames[2] = {8{32'hDEAD_BEEF}};
      frames[3] = {8{32'h3C3C_0F0F}};
      req     = '0;
      reqData = '0;
      for (int i = 0; i < NUM_REQ; i++) reqData[i*INPUT_SIZE +: INPUT_SIZE] = frames[i];
      reset = 1'b1;
      tick(2);
      checkOutput("reset ack", ack, 4'b0000);
      checkOutput("reset ser_start", serStart, 1'b0);
      checkOutput("reset busy", busy, 1'b0);
      checkOutput("reset timeout_err", timeoutErr, 1'b0);
      checkOutput("reset grant_id", grantId, 2'd0);
      checkOutput("reset ser_data", serData, '0);
      reset = 1'b0;

      // Single request: start in cycle 1, ack in cycle 19, lingering req masked.
      vecs[0] = '{1,  4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, "t1 c1"};
      vecs[1] = '{1,  4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, "t1 c2"};
      vecs[2] = '{16, 4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, "t1 c18"};
      vecs[3] = '{1,  4'b0001, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, "t1 c19"};
      vecs[4] = '{1,  4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, "t1 c20 masked"};
      vecs[5] = '{1,  4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, "t1 c21"};
      for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);
      checkOutput("t1 ser_data", serData, frames[0]);

      // All four requesting from reset: grants 0,1,2,3 with starts 19 cycles apart.
      resetDut();
      req = 4'b1111;
      watchGrants(4, {2'd3, 2'd2, 2'd1, 2'd0}, 1, 1'b0, 2'd0, 120);

      // Requester 1 lingers one cycle past its ack; 2 wins, then 3,0,1.
      req = 4'b0110;
      tick(1);
      checkOutput("t3 first start", serStart, 1'b1);
      checkOutput("t3 first grant", grantId, 2'd1);
      tick(18);
      checkOutput("t3 ack1", ack, 4'b0010);
      tick(1);
      checkOutput("t3 ack-cycle start", serStart, 1'b1);
      checkOutput("t3 ack-cycle grant", grantId, 2'd2);
      req = 4'b1111;
      watchGrants(3, {2'd0, 2'd1, 2'd0, 2'd3}, 19, 1'b1, 2'd2, 120);

      // Hung serializer: timeout after 32 WAIT cycles, then the next requester.
      modelNeverDone = 1'b1;
      req = 4'b0011;
      tick(1);
      checkOutput("t4 start", serStart, 1'b1);
      checkOutput("t4 grant", grantId, 2'd0);
      tick(32);
      checkOutput("t4 c33 busy", busy, 1'b1);
      checkOutput("t4 c33 timeout_err", timeoutErr, 1'b0);
      tick(1);
      checkOutput("t4 c34 timeout_err", timeoutErr, 1'b1);
      checkOutput("t4 c34 busy", busy, 1'b0);
      checkOutput("t4 c34 ack", ack, 4'b0000);
      modelNeverDone = 1'b0;
      tick(1);
      checkOutput("t4 retry start", serStart, 1'b1);
      checkOutput("t4 retry grant", grantId, 2'd1);
      tick(18);
      checkOutput("t4 ack1", ack, 4'b0010);
      req = 4'b0001;
      tick(1);
      checkOutput("t4 req0 regrant", grantId, 2'd0);
      checkOutput("t4 req0 start", serStart, 1'b1);
      tick(18);
      checkOutput("t4 ack0", ack, 4'b0001);
      req = 4'b0000;
      tick(1);
      checkOutput("t4 sticky timeout_err", timeoutErr, 1'b1);

      // Reset in the middle of WAIT abandons the frame and restores priority to 0.
      req = 4'b0011;
      tick(1);
      checkOutput("t5 grant before reset", grantId, 2'd1);
      tick(5);
      reset = 1'b1;
      tick(1);
      checkOutput("t5 reset ack", ack, 4'b0000);
      checkOutput("t5 reset ser_start", serStart, 1'b0);
      checkOutput("t5 reset busy", busy, 1'b0);
      checkOutput("t5 reset timeout_err", timeoutErr, 1'b0);
      checkOutput("t5 reset grant_id", grantId, 2'd0);
      checkOutput("t5 reset ser_data", serData, '0);
      reset = 1'b0;
      tick(1);
      checkOutput("t5 release start", serStart, 1'b1);
      checkOutput("t5 release grant", grantId, 2'd0);
      tick(18);
      checkOutput("t5 ack0", ack, 4'b0001);
      req = 4'b0010;
      tick(1);
      checkOutput("t5 grant1", grantId, 2'd1);
      tick(18);
      checkOutput("t5 ack1", ack, 4'b0010);
      req = 4'b0000;
      tick(1);

      // Spurious done while idle, then req_data churn during WAIT.
      serDone = 1'b1;
      tick(1);
      checkOutput("t6 spurious ack", ack, 4'b0000);
      checkOutput("t6 spurious busy", busy, 1'b0);
      tick(1);
      checkOutput("t6 spurious ack2", ack, 4'b0000);
      checkOutput("t6 spurious start", serStart, 1'b0);
      serDone = 1'b0;
      req = 4'b0100;
      tick(1);
      checkOutput("t6 grant", grantId, 2'd2);
      checkOutput("t6 ser_data", serData, frames[2]);
      tick(4);
      reqData[2*INPUT_SIZE +: INPUT_SIZE] = ~frames[2];
      tick(1);
      checkOutput("t6 ser_data held", serData, frames[2]);
      tick(13);
      checkOutput("t6 ack2", ack, 4'b0100);
      req = 4'b0000;
      tick(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
